// File: rtl/sum_job_arbiter.sv
// Round-robin arbiter that time-shares one range-sum accumulator datapath
// among NREQ requesters and returns each result tagged with its requester id.
`timescale 1ns/1ps

module sum_job_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int RW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        lo,
  input  logic [NREQ*W-1:0]        hi,
  output logic [NREQ-1:0]          gnt,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [RW-1:0]            resp_data,
  output logic [W-1:0]             dp_lo,
  output logic [W-1:0]             dp_hi,
  output logic                     ld_counter,
  output logic                     ld_sum,
  output logic                     en_counter,
  output logic                     en_sum,
  input  logic                     done,
  input  logic [RW-1:0]            dp_result
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t         state;
  state_t         next_state;
  logic [IDW-1:0] id;
  logic [IDW-1:0] last_granted;
  logic [IDW-1:0] winner;
  logic           any_req;
  int             cand;

  // Search starts just past the last grant so every requester waits at most NREQ-1 jobs.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_granted) + k) % NREQ;
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = IDW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pointer resets to NREQ-1 so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id           <= '0;
      last_granted <= IDW'(NREQ - 1);
      dp_lo        <= '0;
      dp_hi        <= '0;
      resp_data    <= '0;
      resp_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id    <= winner;
            dp_lo <= lo[winner*W +: W];
            dp_hi <= hi[winner*W +: W];
          end
        end
        LOAD: last_granted <= id;
        RUN: begin
          if (done) begin
            resp_data <= dp_result;
            resp_id   <= id;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt        = '0;
    ld_counter = 1'b0;
    ld_sum     = 1'b0;
    en_counter = 1'b0;
    en_sum     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      LOAD: begin
        gnt[id]    = 1'b1;
        ld_counter = 1'b1;
        ld_sum     = 1'b1;
      end
      RUN: begin
        en_counter = !done;
        en_sum     = !done;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sum_job_arbiter.sv
// Bench for sum_job_arbiter: behavioural counter/accumulator datapaths plus a
// queue of expected responses filled as jobs are requested.
`timescale 1ns/1ps

module tb_sum_job_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] lo, hi;
  logic [3:0]  gnt;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic [7:0]  dp_lo, dp_hi;
  logic        ld_counter, ld_sum, en_counter, en_sum, done;
  logic [15:0] dp_result;

  logic [1:0]  req8;
  logic [15:0] lo8, hi8;
  logic [1:0]  gnt8;
  logic        resp_valid8;
  logic [0:0]  resp_id8;
  logic [7:0]  resp_data8;
  logic [7:0]  dp_lo8, dp_hi8;
  logic        ld_counter8, ld_sum8, en_counter8, en_sum8, done8;
  logic [7:0]  dp_result8;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct { int id; int data; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sum_job_arbiter #(.NREQ(4), .W(8), .RW(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .lo(lo), .hi(hi), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .dp_lo(dp_lo), .dp_hi(dp_hi), .ld_counter(ld_counter), .ld_sum(ld_sum),
    .en_counter(en_counter), .en_sum(en_sum), .done(done), .dp_result(dp_result)
  );

  sum_job_arbiter #(.NREQ(2), .W(8), .RW(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req8), .lo(lo8), .hi(hi8), .gnt(gnt8),
    .resp_valid(resp_valid8), .resp_id(resp_id8), .resp_data(resp_data8),
    .dp_lo(dp_lo8), .dp_hi(dp_hi8), .ld_counter(ld_counter8), .ld_sum(ld_sum8),
    .en_counter(en_counter8), .en_sum(en_sum8), .done(done8), .dp_result(dp_result8)
  );

  // Datapath models: counter is one bit wider so it can pass hi=255.
  logic [8:0]  m_cnt, m_cnt8;
  logic [15:0] m_sum;
  logic [7:0]  m_sum8;

  always @(posedge clk) begin
    if (ld_counter) m_cnt <= {1'b0, dp_lo};
    else if (en_counter) m_cnt <= m_cnt + 9'd1;
    if (ld_sum) m_sum <= '0;
    else if (en_sum) m_sum <= m_sum + 16'(m_cnt);
    if (ld_counter8) m_cnt8 <= {1'b0, dp_lo8};
    else if (en_counter8) m_cnt8 <= m_cnt8 + 9'd1;
    if (ld_sum8) m_sum8 <= '0;
    else if (en_sum8) m_sum8 <= m_sum8 + 8'(m_cnt8);
  end

  assign done       = (m_cnt > {1'b0, dp_hi});
  assign dp_result  = m_sum;
  assign done8      = (m_cnt8 > {1'b0, dp_hi8});
  assign dp_result8 = m_sum8;

  function automatic int sum_range(input int l, input int h, input int rw);
    int s = 0;
    for (int i = l; i <= h; i++) s += i;
    return s & ((1 << rw) - 1);
  endfunction

  // Drives one request on requester idx and records what the DUT does (no checking here).
  task automatic run_single(input int idx, input int l, input int h,
                            output int g_cyc, output logic [3:0] g_vec, output int en_cnt,
                            output int r_cyc, output int r_id, output int r_data);
    g_cyc = -1; g_vec = '0; en_cnt = 0; r_cyc = -1; r_id = -1; r_data = -1;
    @(negedge clk);
    lo[idx*8 +: 8] = 8'(l);
    hi[idx*8 +: 8] = 8'(h);
    req[idx] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (gnt != 4'b0 && g_cyc < 0) begin
        g_cyc = k; g_vec = gnt; req[idx] = 1'b0;
      end
      if (en_sum) en_cnt++;
      if (resp_valid) begin
        r_cyc = k; r_id = int'(resp_id); r_data = int'(resp_data);
        break;
      end
    end
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_job(input string name, input int r_cyc, input int r_id, input int r_data);
    exp_t e;
    tests_run++;
    if (r_cyc < 0 || exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: no response observed (timeout), queue size %0d", name, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (r_id !== e.id || r_data !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL %s: got id=%0d data=%0d, expected id=%0d data=%0d",
                 name, r_id, r_data, e.id, e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; lo = '0; hi = '0; req8 = '0; lo8 = '0; hi8 = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt, resp_valid, resp_id, resp_data, dp_lo, dp_hi,
         ld_counter, ld_sum, en_counter, en_sum} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: gnt=%b rv=%b id=%0d data=%0d lo=%0d hi=%0d ld=%b%b en=%b%b, expected all 0",
               gnt, resp_valid, resp_id, resp_data, dp_lo, dp_hi, ld_counter, ld_sum, en_counter, en_sum);
    end
    tests_run++;
    if ({gnt8, resp_valid8, resp_data8} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rw8: gnt=%b rv=%b data=%0d, expected 0", gnt8, resp_valid8, resp_data8);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int g_cyc, en_cnt, r_cyc, r_id, r_data;
    logic [3:0] g_vec;
    exp_q.push_back('{0, sum_range(1, 100, 16)});
    run_single(0, 1, 100, g_cyc, g_vec, en_cnt, r_cyc, r_id, r_data);
    tests_run++;
    if (g_cyc !== 1 || g_vec !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: cycle=%0d gnt=%b, expected cycle=1 gnt=0001", g_cyc, g_vec);
    end
    tests_run++;
    if (en_cnt !== 100 || r_cyc !== 103) begin
      tests_failed++;
      $display("[TB] FAIL single_timing: en=%0d resp_cycle=%0d, expected en=100 resp_cycle=103", en_cnt, r_cyc);
    end
    check_job("single_result", r_cyc, r_id, r_data);
  endtask

  task automatic test_empty_range();
    int g_cyc, en_cnt, r_cyc, r_id, r_data;
    logic [3:0] g_vec;
    exp_q.push_back('{1, 0});
    run_single(1, 5, 4, g_cyc, g_vec, en_cnt, r_cyc, r_id, r_data);
    tests_run++;
    if (en_cnt !== 0 || r_cyc !== 3) begin
      tests_failed++;
      $display("[TB] FAIL empty_timing: en=%0d resp_cycle=%0d, expected en=0 resp_cycle=3", en_cnt, r_cyc);
    end
    check_job("empty_result", r_cyc, r_id, r_data);
  endtask

  task automatic test_degenerate_range();
    int g_cyc, en_cnt, r_cyc, r_id, r_data;
    logic [3:0] g_vec;
    exp_q.push_back('{2, 7});
    run_single(2, 7, 7, g_cyc, g_vec, en_cnt, r_cyc, r_id, r_data);
    tests_run++;
    if (en_cnt !== 1 || r_cyc !== 4 || g_vec !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL degenerate_timing: en=%0d resp_cycle=%0d gnt=%b, expected en=1 resp_cycle=4 gnt=0100",
               en_cnt, r_cyc, g_vec);
    end
    check_job("degenerate_result", r_cyc, r_id, r_data);
  endtask

  task automatic test_overflow();
    int g_cyc, en_cnt, r_cyc, r_id, r_data;
    logic [3:0] g_vec;
    exp_q.push_back('{3, sum_range(0, 255, 16)});
    run_single(3, 0, 255, g_cyc, g_vec, en_cnt, r_cyc, r_id, r_data);
    tests_run++;
    if (en_cnt !== 256 || r_cyc !== 259) begin
      tests_failed++;
      $display("[TB] FAIL full_range_timing: en=%0d resp_cycle=%0d, expected en=256 resp_cycle=259", en_cnt, r_cyc);
    end
    check_job("full_range_result", r_cyc, r_id, r_data);
  endtask

  task automatic test_overflow_rw8();
    int r_cyc = -1, r_id = -1, r_data = -1;
    exp_q.push_back('{0, sum_range(1, 30, 8)});
    @(negedge clk);
    lo8[7:0] = 8'd1; hi8[7:0] = 8'd30; req8[0] = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (gnt8[0]) req8[0] = 1'b0;
      if (resp_valid8) begin
        r_cyc = k; r_id = int'(resp_id8); r_data = int'(resp_data8);
        break;
      end
    end
    req8 = '0;
    tests_run++;
    if (r_cyc !== 33) begin
      tests_failed++;
      $display("[TB] FAIL rw8_timing: resp_cycle=%0d, expected 33", r_cyc);
    end
    check_job("rw8_wrap_result", r_cyc, r_id, r_data);
  endtask

  task automatic test_round_robin();
    int ord[5] = '{0, 1, 2, 3, 0};
    int g = 0, r = 0, last_g = -1, rid, rdata;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lo = {4{8'd1}}; hi = {4{8'd4}}; req = 4'hF;
    for (int i = 0; i < 5; i++) exp_q.push_back('{ord[i], sum_range(1, 4, 16)});
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        if (g < 5) begin
          tests_run++;
          if (gnt !== 4'(1 << ord[g])) begin
            tests_failed++;
            $display("[TB] FAIL rr_order[%0d]: gnt=%b, expected %b", g, gnt, 4'(1 << ord[g]));
          end
          if (g > 0) begin
            tests_run++;
            if (k - last_g !== 8) begin
              tests_failed++;
              $display("[TB] FAIL rr_spacing[%0d]: %0d cycles between grants, expected 8", g, k - last_g);
            end
          end
          last_g = k;
        end
        g++;
        if (g == 5) req = '0;
      end
      if (resp_valid) begin
        rid = int'(resp_id); rdata = int'(resp_data);
        check_job("rr_result", k, rid, rdata);
        r++;
        if (r == 5) break;
      end
    end
    req = '0;
    tests_run++;
    if (r !== 5 || g !== 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_counts: responses=%0d grants=%0d, expected 5 and 5", r, g);
    end
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    int n_resp = 0, n_gnt0 = 0, n_gnt1 = 0, rid, rdata;
    exp_q.push_back('{0, sum_range(1, 10, 16)});
    @(negedge clk);
    lo[7:0] = 8'd1; hi[7:0] = 8'd10; req[0] = 1'b1;
    lo[15:8] = 8'd2; hi[15:8] = 8'd3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (gnt[0]) begin n_gnt0++; req[0] = 1'b0; end
      if (gnt[1]) n_gnt1++;
      req[1] = (k == 5);
      if (resp_valid) begin
        n_resp++;
        rid = int'(resp_id); rdata = int'(resp_data);
        check_job("withdrawn_result", k, rid, rdata);
      end
    end
    req = '0;
    tests_run++;
    if (n_resp !== 1 || n_gnt0 !== 1 || n_gnt1 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL withdrawn_counts: resp=%0d gnt0=%0d gnt1=%0d, expected 1 1 0", n_resp, n_gnt0, n_gnt1);
    end
    tests_run++;
    if ({gnt, ld_counter, ld_sum, en_counter, en_sum, resp_valid} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL withdrawn_idle: gnt=%b ld=%b%b en=%b%b rv=%b, expected all 0",
               gnt, ld_counter, ld_sum, en_counter, en_sum, resp_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    int n_resp = 0, g_cyc, en_cnt, r_cyc, r_id, r_data;
    logic [3:0] g_vec;
    @(negedge clk);
    lo[7:0] = 8'd1; hi[7:0] = 8'd100; req[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
    end
    req = '0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({gnt, resp_valid, resp_id, resp_data, dp_lo, dp_hi,
         ld_counter, ld_sum, en_counter, en_sum} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midjob_reset_outputs: gnt=%b rv=%b id=%0d data=%0d lo=%0d hi=%0d en=%b%b, expected all 0",
               gnt, resp_valid, resp_id, resp_data, dp_lo, dp_hi, en_counter, en_sum);
    end
    rst = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    tests_run++;
    if (n_resp !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midjob_no_resp: %0d responses after reset, expected 0", n_resp);
    end
    exp_q.push_back('{2, sum_range(1, 3, 16)});
    run_single(2, 1, 3, g_cyc, g_vec, en_cnt, r_cyc, r_id, r_data);
    check_job("midjob_new_job", r_cyc, r_id, r_data);
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_range();
    test_degenerate_range();
    test_overflow();
    test_overflow_rw8();
    test_round_robin();
    test_withdrawn();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
